framebuffer_fill_writer: RTL and testbench

FRAMEBUFFER_FILL_WRITER -- requirements
Module: framebuffer_fill_writer

---
 rtl/framebuffer_fill_writer_if.sv | 36 +++
 rtl/framebuffer_fill_writer.sv | 154 +++++++++++++++
 tb/tb_framebuffer_fill_writer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_fill_writer_if.sv
//==============================================================================
// framebuffer_fill_writer_if: fill-command handshake and image-RAM write port.
// Rev 1.0
//==============================================================================
`default_nettype none

interface framebuffer_fill_writer_if #(
  parameter int DATA_WIDTH    = 9,
  parameter int ADDRESS_WIDTH = 20
);
  logic                     cmdValid;
  logic                     cmdReady;
  logic [9:0]               cmdX;
  logic [9:0]               cmdY;
  logic [9:0]               cmdW;
  logic [9:0]               cmdH;
  logic [DATA_WIDTH-1:0]    cmdColor;
  logic                     stall;
  logic                     wEn;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    wData;
  logic                     busy;
  logic                     done;

  modport master (
    output cmdValid, cmdX, cmdY, cmdW, cmdH, cmdColor, stall,
    input  cmdReady, wEn, addr, wData, busy, done
  );

  modport slave (
    input  cmdValid, cmdX, cmdY, cmdW, cmdH, cmdColor, stall,
    output cmdReady, wEn, addr, wData, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/framebuffer_fill_writer.sv
//==============================================================================
// framebuffer_fill_writer: clipped rectangle fill, one pixel per unstalled cycle.
// Rev 1.0
//==============================================================================
`default_nettype none

module framebuffer_fill_writer #(
  parameter int WIDTH         = 640,
  parameter int HEIGHT        = 480,
  parameter int DATA_WIDTH    = 9,
  parameter int ADDRESS_WIDTH = 20
) (
  input  wire logic              clk,
  input  wire logic              reset,
  framebuffer_fill_writer_if.slave bus
);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_SETUP = 2'd1;
  localparam logic [1:0] c_S_WRITE = 2'd2;
  localparam logic [1:0] c_S_DONE  = 2'd3;

  localparam logic [10:0]              c_WIDTH11  = 11'(WIDTH);
  localparam logic [10:0]              c_HEIGHT11 = 11'(HEIGHT);
  localparam logic [ADDRESS_WIDTH-1:0] c_ROW_STEP = ADDRESS_WIDTH'(WIDTH);

  logic [1:0]               state_q, state_d;
  logic [9:0]               x_q, y_q, w_q, h_q;
  logic [DATA_WIDTH-1:0]    color_q;
  logic [9:0]               col_q, col_d;
  logic [9:0]               row_q, row_d;
  logic [10:0]              x_end_q, x_end_d;
  logic [10:0]              y_end_q, y_end_d;
  logic [ADDRESS_WIDTH-1:0] row_base_q, row_base_d;
  logic                     wen_q, wen_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic        w_accept;
  logic        w_degenerate;
  logic        w_last_col;
  logic        w_last_row;
  logic [10:0] w_x_sum;
  logic [10:0] w_y_sum;

  assign w_accept     = bus.cmdValid && (state_q == c_S_IDLE);
  assign w_x_sum      = {1'b0, x_q} + {1'b0, w_q};
  assign w_y_sum      = {1'b0, y_q} + {1'b0, h_q};
  assign w_degenerate = (w_q == 10'd0) || (h_q == 10'd0) ||
                        ({1'b0, x_q} >= c_WIDTH11) || ({1'b0, y_q} >= c_HEIGHT11);
  assign w_last_col   = ({1'b0, col_q} == (x_end_q - 11'd1));
  assign w_last_row   = ({1'b0, row_q} == (y_end_q - 11'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= c_S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      row_base_q <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (w_accept) begin
        x_q     <= bus.cmdX;
        y_q     <= bus.cmdY;
        w_q     <= bus.cmdW;
        h_q     <= bus.cmdH;
        color_q <= bus.cmdColor;
      end
      col_q      <= col_d;
      row_q      <= row_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      row_base_q <= row_base_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_S_IDLE:  if (w_accept) state_d = c_S_SETUP;
      c_S_SETUP: state_d = w_degenerate ? c_S_DONE : c_S_WRITE;
      c_S_WRITE: if (!bus.stall && w_last_col && w_last_row) state_d = c_S_DONE;
      c_S_DONE:  state_d = c_S_IDLE;
      default:   state_d = c_S_IDLE;
    endcase
  end

  // The only multiply happens in SETUP; rows advance by adding WIDTH.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    row_base_d = row_base_q;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = (state_q != c_S_IDLE);
    done_d     = (state_q == c_S_DONE);
    case (state_q)
      c_S_SETUP: begin
        x_end_d    = (w_x_sum > c_WIDTH11)  ? c_WIDTH11  : w_x_sum;
        y_end_d    = (w_y_sum > c_HEIGHT11) ? c_HEIGHT11 : w_y_sum;
        row_base_d = ADDRESS_WIDTH'(y_q) * c_ROW_STEP;
        col_d      = x_q;
        row_d      = y_q;
      end
      c_S_WRITE: begin
        if (!bus.stall) begin
          wen_d   = 1'b1;
          addr_d  = row_base_q + ADDRESS_WIDTH'(col_q);
          wdata_d = color_q;
          if (w_last_col) begin
            col_d      = x_q;
            row_d      = row_q + 10'd1;
            row_base_d = row_base_q + c_ROW_STEP;
          end else begin
            col_d = col_q + 10'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.cmdReady = (state_q == c_S_IDLE);
  assign bus.wEn      = wen_q;
  assign bus.addr     = addr_q;
  assign bus.wData    = wdata_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_framebuffer_fill_writer.sv
//==============================================================================
// tb_framebuffer_fill_writer: directed fills checked against a pixel-list model.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_framebuffer_fill_writer;

  localparam int FBW = 640;
  localparam int FBH = 480;

  logic clk = 1'b0;
  logic reset;

  framebuffer_fill_writer_if #(.DATA_WIDTH(9), .ADDRESS_WIDTH(20)) bif ();

  framebuffer_fill_writer #(
    .WIDTH(FBW), .HEIGHT(FBH), .DATA_WIDTH(9), .ADDRESS_WIDTH(20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Model: a command expands into its clipped pixel list up front.
  int unsigned pq[$];
  bit          m_idle  = 1'b1;
  int          m_phase = 0;
  int          m_color = 0;
  bit          started = 1'b0;
  int          edge_n  = 0;
  int          acc_edge = 0;
  int          m_log_cyc[$];
  int          m_log_adr[$];
  int          m_log_dat[$];
  int          m_done_cyc = -1;
  logic        e_wen, e_busy, e_done;
  logic [19:0] e_addr;
  logic [8:0]  e_wdata;

  always @(posedge clk) begin
    logic s_rst, s_v, s_stall;
    int   s_x, s_y, s_w, s_h, s_c, xe, ye;
    edge_n++;
    s_rst   = reset;
    s_v     = bif.cmdValid;
    s_stall = bif.stall;
    s_x = int'(bif.cmdX); s_y = int'(bif.cmdY);
    s_w = int'(bif.cmdW); s_h = int'(bif.cmdH);
    s_c = int'(bif.cmdColor);
    if (s_rst) begin
      pq.delete();
      m_idle = 1'b1;
      e_wen = 1'b0; e_addr = '0; e_wdata = '0; e_busy = 1'b0; e_done = 1'b0;
      started = 1'b1;
    end else if (started) begin
      e_busy = !m_idle;
      e_wen  = 1'b0;
      e_done = 1'b0;
      if (m_idle) begin
        if (s_v) begin
          xe = (s_x + s_w > FBW) ? FBW : s_x + s_w;
          ye = (s_y + s_h > FBH) ? FBH : s_y + s_h;
          for (int r = s_y; r < ye; r++)
            for (int c = s_x; c < xe; c++)
              pq.push_back(r * FBW + c);
          m_color  = s_c;
          m_idle   = 1'b0;
          m_phase  = 0;
          acc_edge = edge_n;
        end
      end else if (m_phase == 0) begin
        m_phase = (pq.size() > 0) ? 1 : 2;
      end else if (m_phase == 1) begin
        if (!s_stall) begin
          e_wen   = 1'b1;
          e_addr  = 20'(pq.pop_front());
          e_wdata = 9'(m_color);
          m_log_cyc.push_back(edge_n - acc_edge);
          m_log_adr.push_back(int'(e_addr));
          m_log_dat.push_back(m_color);
          if (pq.size() == 0) m_phase = 2;
        end
      end else begin
        e_done     = 1'b1;
        m_idle     = 1'b1;
        m_done_cyc = edge_n - acc_edge;
      end
    end
    #1;
    if (started) begin
      chk("wEn",      32'(bif.wEn),      32'(e_wen));
      chk("addr",     32'(bif.addr),     32'(e_addr));
      chk("wData",    32'(bif.wData),    32'(e_wdata));
      chk("busy",     32'(bif.busy),     32'(e_busy));
      chk("done",     32'(bif.done),     32'(e_done));
      chk("cmdReady", 32'(bif.cmdReady), 32'(m_idle));
    end
  end

  int e_cyc[$];
  int e_adr[$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_log(input string tag, input int dcyc, input int color);
    chk({tag, "_nwrites"}, 32'(m_log_cyc.size()), 32'(e_cyc.size()));
    for (int k = 0; k < e_cyc.size() && k < m_log_cyc.size(); k++) begin
      chk({tag, "_cycle"}, 32'(m_log_cyc[k]), 32'(e_cyc[k]));
      chk({tag, "_addr"},  32'(m_log_adr[k]), 32'(e_adr[k]));
      chk({tag, "_data"},  32'(m_log_dat[k]), 32'(color));
    end
    chk({tag, "_done_cycle"}, 32'(m_done_cyc), 32'(dcyc));
  endtask

  task automatic run_cmd(input int x, input int y, input int w, input int h, input int c,
                         input int st_lo, input int st_hi, input int rst_at,
                         input bit hold, input int exp_done);
    bit found;
    int limit;
    m_log_cyc.delete(); m_log_adr.delete(); m_log_dat.delete();
    m_done_cyc = -1;
    found = 1'b0;
    limit = (exp_done < 0) ? 10 : 60;
    bif.cmdValid = 1'b1;
    bif.cmdX = 10'(x); bif.cmdY = 10'(y);
    bif.cmdW = 10'(w); bif.cmdH = 10'(h);
    bif.cmdColor = 9'(c);
    bif.stall = 1'b0;
    tick();
    if (hold) begin
      bif.cmdX = 10'd100;
      bif.cmdColor = 9'h022;
    end else begin
      bif.cmdValid = 1'b0;
    end
    for (int i = 1; i <= limit; i++) begin
      bif.stall = (i >= st_lo) && (i <= st_hi);
      reset     = (i == rst_at);
      tick();
      reset = 1'b0;
      if (exp_done >= 0 && bif.done === 1'b1) begin
        chk("done_cycle_dut", 32'(i), 32'(exp_done));
        found = 1'b1;
        break;
      end
    end
    bif.cmdValid = 1'b0;
    bif.stall    = 1'b0;
    reset        = 1'b0;
    if (exp_done >= 0 && !found) chk("done_timeout", 32'(0), 32'(1));
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bif.cmdValid = 1'b1;
    bif.stall = 1'b1;
    bif.cmdX = 10'd1; bif.cmdY = 10'd1; bif.cmdW = 10'd2; bif.cmdH = 10'd2;
    bif.cmdColor = 9'h1;
    repeat (3) tick();
    chk("rst_wEn",      32'(bif.wEn),      32'd0);
    chk("rst_addr",     32'(bif.addr),     32'd0);
    chk("rst_wData",    32'(bif.wData),    32'd0);
    chk("rst_busy",     32'(bif.busy),     32'd0);
    chk("rst_done",     32'(bif.done),     32'd0);
    chk("rst_cmdReady", 32'(bif.cmdReady), 32'd1);
    reset = 1'b0;
    bif.cmdValid = 1'b0;
    bif.stall = 1'b0;
    tick();

    run_cmd(2, 3, 3, 2, 'h05, 0, -1, -1, 1'b0, 8);
    e_cyc = '{2, 3, 4, 5, 6, 7};
    e_adr = '{1922, 1923, 1924, 2562, 2563, 2564};
    check_log("fill3x2", 8, 'h05);

    run_cmd(638, 479, 10, 10, 'h1FF, 0, -1, -1, 1'b0, 4);
    e_cyc = '{2, 3};
    e_adr = '{307198, 307199};
    check_log("clip", 4, 'h1FF);

    run_cmd(5, 5, 0, 3, 'h07, 0, -1, -1, 1'b0, 2);
    e_cyc.delete(); e_adr.delete();
    check_log("w0", 2, 'h07);

    run_cmd(640, 0, 4, 4, 'h03, 0, -1, -1, 1'b0, 2);
    check_log("x640", 2, 'h03);

    run_cmd(0, 0, 4, 1, 'h0C, 3, 4, -1, 1'b0, 8);
    e_cyc = '{2, 5, 6, 7};
    e_adr = '{0, 1, 2, 3};
    check_log("stall", 8, 'h0C);

    run_cmd(10, 0, 3, 2, 'h11, 0, -1, -1, 1'b1, 8);
    e_cyc = '{2, 3, 4, 5, 6, 7};
    e_adr = '{10, 11, 12, 650, 651, 652};
    check_log("held_valid", 8, 'h11);

    run_cmd(2, 3, 3, 2, 'h05, 0, -1, 4, 1'b0, -1);
    e_cyc = '{2, 3};
    e_adr = '{1922, 1923};
    check_log("abort", -1, 'h05);
    chk("abort_cmdReady", 32'(bif.cmdReady), 32'd1);

    run_cmd(0, 1, 2, 1, 'h07, 0, -1, -1, 1'b0, 4);
    e_cyc = '{2, 3};
    e_adr = '{640, 641};
    check_log("after_abort", 4, 'h07);

    run_cmd(639, 100, 1, 1, 'h0AB, 0, -1, -1, 1'b0, 3);
    e_cyc = '{2};
    e_adr = '{64639};
    check_log("corner_px", 3, 'h0AB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
